// File: rtl/rr_grant_arbiter8_pkg.sv
// Shared definitions for the 8-way round-robin grant arbiter.
//   state_t : arbiter FSM states (IDLE, GRANT)
//   NUM_REQ : number of requesters
//   IDX_W   : width of a requester index
package rr_grant_arbiter8_pkg;

    localparam int NUM_REQ = 8;
    localparam int IDX_W   = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

endpackage

// File: rtl/rr_grant_arbiter8_onehot_dec3to8.sv
// 3-to-8 one-hot decoder with enable, purely combinational.
// Ports:
//   in  [2:0] : index to decode
//   en        : when low, all outputs are zero
//   out [7:0] : one-hot decode of in, gated by en
module onehot_dec3to8 (
    input  logic [2:0] in,
    input  logic       en,
    output logic [7:0] out
);

    for (genvar gi = 0; gi < 8; gi++) begin : g_dec
        assign out[gi] = en && (in == 3'(gi));
    end

endmodule

// File: rtl/rr_grant_arbiter8.sv
// Round-robin arbiter sharing one 8-way decoded resource-select between
// 8 requesters. A grant is held until the owner signals done, drops its
// request, or has held the resource for HOLD_LIMIT cycles. A dead cycle
// always separates consecutive grants.
// Parameters:
//   CNT_W      : hold counter width
//   HOLD_LIMIT : grant cycles before forced release (0 disables); < 2^CNT_W
// Ports:
//   clk       : system clock, rising edge
//   rst       : asynchronous active-high reset
//   req [7:0] : level requests
//   done      : owner's last cycle of use (ignored while idle)
//   gnt [7:0] : one-hot grant, zero when no grant is active
//   gnt_idx   : index of current owner
//   gnt_valid : a grant is active
//   timeout   : one-cycle pulse after a release caused only by the hold limit
module rr_grant_arbiter8
    import rr_grant_arbiter8_pkg::*;
#(
    parameter int CNT_W      = 4,
    parameter int HOLD_LIMIT = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               done,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_valid,
    output logic               timeout
);

    localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(HOLD_LIMIT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    // Rotate requests so the pointer position is bit 0, find the lowest set
    // bit, then add the pointer back (mod 8 via the 3-bit result width).
    function automatic logic [IDX_W-1:0] rr_pick(
        input logic [NUM_REQ-1:0] r,
        input logic [IDX_W-1:0]   p
    );
        logic [2*NUM_REQ-1:0] dbl;
        logic [NUM_REQ-1:0]   rot;
        logic [IDX_W-1:0]     off;
        dbl = {r, r};
        rot = dbl[p +: NUM_REQ];
        off = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) off = IDX_W'(i);
        end
        return off + p;
    endfunction

    state_t           state_reg, state_next;
    logic [IDX_W-1:0] ptr_reg, ptr_next;
    logic [IDX_W-1:0] idx_reg, idx_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             timeout_reg, timeout_next;

    logic owner_req;
    logic limit_hit;
    logic release_now;

    assign owner_req   = req[idx_reg];
    assign limit_hit   = (HOLD_LIMIT != 0) && (cnt_reg == LIMIT_M1);
    assign release_now = done || !owner_req || limit_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            ptr_reg     <= '0;
            idx_reg     <= '0;
            cnt_reg     <= '0;
            timeout_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            ptr_reg     <= ptr_next;
            idx_reg     <= idx_next;
            cnt_reg     <= cnt_next;
            timeout_reg <= timeout_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        ptr_next     = ptr_reg;
        idx_next     = idx_reg;
        cnt_next     = cnt_reg;
        timeout_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (|req) begin
                    idx_next   = rr_pick(req, ptr_reg);
                    cnt_next   = '0;
                    state_next = GRANT;
                end
            end
            GRANT: begin
                if (release_now) begin
                    state_next   = IDLE;
                    ptr_next     = idx_reg + IDX_W'(1);
                    cnt_next     = '0;
                    // A coincident done or withdrawal makes it a normal release.
                    timeout_next = limit_hit && !done && owner_req;
                end else if ((HOLD_LIMIT != 0) && (cnt_reg != CNT_MAX)) begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign gnt_valid = (state_reg == GRANT);
    assign gnt_idx   = idx_reg;
    assign timeout   = timeout_reg;

    onehot_dec3to8 u_dec (
        .in  (idx_reg),
        .en  (gnt_valid),
        .out (gnt)
    );

endmodule

// File: doc/rr_grant_arbiter8.md
Name: rr_grant_arbiter8

Overview:
- Round-robin arbiter that shares one 8-way resource-select between 8 requesters.
- Winner index is registered; a 3-to-8 one-hot decode, gated by grant-valid, drives the resource enables.
- Grant is held until the owner finishes, withdraws its request, or exceeds a hold limit.
- Sits between requester agents and the shared decoded-select datapath.

Parameters:
- CNT_W, 4, width of the hold counter.
- HOLD_LIMIT, 15, maximum grant cycles before a forced release. 0 disables the timeout. Must be < 2^CNT_W.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  8  request per requester; level, held until granted/done.
- done  input  1  owner signals last cycle of use; qualified only while gnt_valid.
- gnt  output  8  one-hot grant, decoded from gnt_idx; all zero when gnt_valid=0.
- gnt_idx  output  3  index of current owner.
- gnt_valid  output  1  a grant is active.
- timeout  output  1  one-cycle pulse on forced release.

Behaviour:
- Reset (async, active-high): gnt=0, gnt_idx=0, gnt_valid=0, timeout=0, state=IDLE, priority pointer ptr=0, hold counter=0. All outputs clear immediately on rst assertion, including mid-grant.
- States: IDLE, GRANT.
- IDLE:
  - If req != 0, pick the first set bit scanning ptr, ptr+1, ..., wrapping 7->0.
  - On the next edge: gnt_idx=winner, gnt_valid=1, counter=0, state=GRANT.
  - If req == 0, remain in IDLE.
  - Latency: req sampled at edge t -> gnt visible after edge t.
- GRANT: release condition R = done OR !req[gnt_idx] OR (HOLD_LIMIT != 0 AND counter == HOLD_LIMIT-1).
  - If R: next edge gnt_valid=0, ptr=(gnt_idx+1) mod 8, state=IDLE, counter=0.
  - Else: counter+1.
- One dead cycle (gnt=0) always separates consecutive grants, including a re-grant to the same requester.
- timeout = 1 for exactly the cycle after a release caused solely by the hold limit.
  - If done or request withdrawal coincides with the limit, it is a normal release and timeout stays 0.
- done while IDLE is ignored.
- Arbitration is combinational from req/ptr in IDLE; all outputs are registered.
- gnt = decode(gnt_idx) when gnt_valid, else 8'd0.
- Requests from non-owners during GRANT have no effect until IDLE.
- The counter saturates and never wraps; with HOLD_LIMIT=0 it is not incremented.
- Fairness bound: with all 8 requesting and a hold of H cycles each, any requester waits at most 7*(H+1) cycles.

Decomposition:
- Shared package:
  - state enum {IDLE, GRANT};
  - constant NUM_REQ=8;
  - constant IDX_W=3.
- One sub-module: onehot_dec3to8 (inputs in[2:0], en; output out[7:0]), purely combinational, used for the gnt output.
- The round-robin pick (rotate, priority-find, unrotate) stays in the top as a function.

Test Plan:
- Single request: req=8'b0000_0100 from reset, done pulsed on the 3rd grant cycle -> gnt=8'h04, gnt_idx=2 one cycle after req; gnt=0 the cycle after done; next ptr=3.
- All request: req=8'hFF, done asserted every grant cycle -> grant order idx 0,1,2,...,7,0 with gnt=0 between each grant; gnt never has >1 bit set.
- Wrap and skip: ptr=6, req=8'b0010_0001 -> winner idx 0 (6,7 idle; wrap); then ptr=1 and req=8'h21 -> winner idx 5.
- Timeout: HOLD_LIMIT=4, req[3] held, done=0 -> gnt_valid high exactly 4 cycles, then timeout=1 for 1 cycle with gnt=0; the next grant goes to another requester if one is pending.
- Coincident done and limit: HOLD_LIMIT=4, done asserted on the 4th grant cycle -> release with timeout=0.
- Async reset mid-grant: assert rst between edges while gnt=8'h10 -> gnt, gnt_valid and timeout go to 0 before the next edge; after deassert, req=8'hFF grants idx 0 first.
